link_master_fsm: RTL and testbench

LINK_MASTER_FSM -- requirements
Module: link_master_fsm

---
 rtl/link_pkg.sv | 16 +
 rtl/link_fifo.sv | 59 +++++
 rtl/link_master_fsm.sv | 151 +++++++++++++++
 tb/tb_link_master_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/link_pkg.sv
// Shared definitions for the link master: FSM state encoding, byte width and
// default sizing of the byte queue and ack timeout.
package link_pkg;

  localparam int BYTE_W      = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ_HI  = 2'd1,
    ST_WAIT_LO = 2'd2,
    ST_ERR     = 2'd3
  } link_state_e;

endpackage

// File: rtl/link_fifo.sv
// Byte queue for the link master. DEPTH must be a power of two so the
// read/write pointers wrap naturally. A push while full is refused even
// if a pop happens in the same cycle.
module link_fifo
  import link_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WIDTH = BYTE_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == {CW{1'b0}});
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array; contents need no reset because occupancy gates reads.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/link_master_fsm.sv
// Link master: drains a byte queue onto a req/ack four-phase link, aborting
// to an error state when the slave does not ack within TIMEOUT cycles.
module link_master_fsm
  import link_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              req,
  output logic [BYTE_W-1:0] data,
  input  logic              ack,
  input  logic              clear_err,
  output logic              busy,
  output logic              done,
  output logic [7:0]        tx_count,
  output logic              timeout_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  link_state_e       r_state,   w_state_nxt;
  logic              r_req,     w_req_nxt;
  logic [BYTE_W-1:0] r_data,    w_data_nxt;
  logic              r_done,    w_done_nxt;
  logic [7:0]        r_tx_cnt,  w_tx_cnt_nxt;
  logic              r_err,     w_err_nxt;
  logic [WW-1:0]     r_wait,    w_wait_nxt;
  logic [WW-1:0]     w_wait_inc;

  logic              w_push;
  logic              w_pop;
  logic [BYTE_W-1:0] w_head;
  logic              w_full;
  logic              w_empty;
  logic [CW-1:0]     w_count;

  link_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (in_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign in_ready    = (w_count < CW'(DEPTH));
  assign w_push      = in_valid & ~w_full;
  assign busy        = (r_state != ST_IDLE) | ~w_empty;
  assign req         = r_req;
  assign data        = r_data;
  assign done        = r_done;
  assign tx_count    = r_tx_cnt;
  assign timeout_err = r_err;
  assign w_wait_inc  = r_wait + WW'(1);

  // Next-state and next-output decode for the link handshake.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_nxt    = r_req;
    w_data_nxt   = r_data;
    w_done_nxt   = 1'b0;
    w_tx_cnt_nxt = r_tx_cnt;
    w_err_nxt    = r_err;
    w_wait_nxt   = r_wait;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // ack still high from the previous slave cycle blocks a new pop.
        if (!w_empty && !ack) begin
          w_pop       = 1'b1;
          w_data_nxt  = w_head;
          w_req_nxt   = 1'b1;
          w_wait_nxt  = {WW{1'b0}};
          w_state_nxt = ST_REQ_HI;
        end else begin
          w_req_nxt   = 1'b0;
        end
      end
      ST_REQ_HI: begin
        if (ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = ST_WAIT_LO;
        end else if (w_wait_inc == WW'(TIMEOUT)) begin
          // Abort: the popped byte is dropped and the error is latched.
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_wait_nxt  = w_wait_inc;
          w_state_nxt = ST_ERR;
        end else begin
          w_wait_nxt  = w_wait_inc;
        end
      end
      ST_WAIT_LO: begin
        if (!ack) begin
          w_done_nxt   = 1'b1;
          w_tx_cnt_nxt = r_tx_cnt + 8'd1;
          w_state_nxt  = ST_IDLE;
        end else begin
          w_state_nxt  = ST_WAIT_LO;
        end
      end
      ST_ERR: begin
        w_req_nxt = 1'b0;
        if (clear_err && !ack) begin
          w_err_nxt   = 1'b0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ERR;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and registered link outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_req    <= 1'b0;
      r_data   <= {BYTE_W{1'b0}};
      r_done   <= 1'b0;
      r_tx_cnt <= 8'd0;
      r_err    <= 1'b0;
      r_wait   <= {WW{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_req    <= w_req_nxt;
      r_data   <= w_data_nxt;
      r_done   <= w_done_nxt;
      r_tx_cnt <= w_tx_cnt_nxt;
      r_err    <= w_err_nxt;
      r_wait   <= w_wait_nxt;
    end
  end

endmodule

// File: tb/tb_link_master_fsm.sv
// Directed bench for link_master_fsm (DEPTH=4, TIMEOUT=15). Inputs change
// and outputs are sampled on the falling edge.
module tb_link_master_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready;
  logic       req;
  logic [7:0] data;
  logic       ack = 1'b0;
  logic       clear_err = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] tx_count;
  logic       timeout_err;

  int n_vec = 0;
  int n_err = 0;

  link_master_fsm #(.DEPTH(4), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .req         (req),
    .data        (data),
    .ack         (ack),
    .clear_err   (clear_err),
    .busy        (busy),
    .done        (done),
    .tx_count    (tx_count),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Slave side of one transfer: wait for req, ack it, hold ack 'hold' cycles.
  task automatic slave_xfer(input logic [7:0] exp, input int hold);
    int t = 0;
    while (req !== 1'b1 && t < 40) begin
      tick();
      t++;
    end
    check_vec("req_rise", req, 1);
    check_vec("req_data", data, exp);
    ack = 1'b1;
    tick();
    check_vec("req_drop", req, 0);
    check_vec("data_hold", data, exp);
    for (int i = 1; i < hold; i++) begin
      tick();
      check_vec("wait_lo_req", req, 0);
      check_vec("wait_lo_done", done, 0);
    end
    ack = 1'b0;
    tick();
    check_vec("done_pulse", done, 1);
    check_vec("done_req", req, 0);
    check_vec("done_data", data, exp);
  endtask

  initial begin
    int n;
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_vec("rst_req", req, 0);
    check_vec("rst_data", data, 0);
    check_vec("rst_done", done, 0);
    check_vec("rst_tx", tx_count, 0);
    check_vec("rst_err", timeout_err, 0);
    check_vec("rst_ready", in_ready, 1);
    check_vec("rst_busy", busy, 0);
    rst = 1'b1;
    tick();

    // Single byte, ack after 1 cycle, held 3 cycles
    push_byte(8'hA5);
    check_vec("a5_req_lag", req, 0);
    check_vec("a5_busy", busy, 1);
    slave_xfer(8'hA5, 3);
    check_vec("a5_tx", tx_count, 1);
    tick();
    check_vec("a5_done_once", done, 0);
    check_vec("a5_idle", busy, 0);

    // Fill the queue while ack=1 holds the FSM in IDLE, then drain
    ack = 1'b1;
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    push_byte(8'h04);
    check_vec("fill_ready", in_ready, 0);
    check_vec("fill_ack_idle", req, 0);
    push_byte(8'h05);
    check_vec("fill_refused", in_ready, 0);
    ack = 1'b0;
    slave_xfer(8'h01, 1);
    slave_xfer(8'h02, 1);
    slave_xfer(8'h03, 1);
    slave_xfer(8'h04, 1);
    check_vec("fill_tx", tx_count, 5);
    tick();
    tick();
    check_vec("fill_no5_req", req, 0);
    check_vec("fill_no5_busy", busy, 0);

    // Push while full with a same-cycle pop
    ack = 1'b1;
    push_byte(8'h11);
    push_byte(8'h12);
    push_byte(8'h13);
    push_byte(8'h14);
    check_vec("full2_ready", in_ready, 0);
    ack = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h15;
    tick();
    in_valid = 1'b0;
    check_vec("pushpop_ready", in_ready, 1);
    check_vec("pushpop_req", req, 1);
    slave_xfer(8'h11, 1);
    slave_xfer(8'h12, 1);
    slave_xfer(8'h13, 1);
    slave_xfer(8'h14, 1);
    tick();
    tick();
    check_vec("pushpop_no15_req", req, 0);
    check_vec("pushpop_no15_busy", busy, 0);
    check_vec("pushpop_tx", tx_count, 9);

    // Timeout with ack tied low
    push_byte(8'h3C);
    tick();
    n = 0;
    while (req === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check_vec("to_req_cycles", n, 15);
    check_vec("to_err", timeout_err, 1);
    check_vec("to_err_busy", busy, 1);
    push_byte(8'h77);
    check_vec("err_no_req", req, 0);
    check_vec("err_ready", in_ready, 1);
    clear_err = 1'b1;
    ack = 1'b1;
    tick();
    check_vec("clr_blocked_ack", timeout_err, 1);
    ack = 1'b0;
    tick();
    clear_err = 1'b0;
    check_vec("clr_err", timeout_err, 0);
    check_vec("clr_req", req, 0);
    check_vec("clr_tx", tx_count, 9);
    slave_xfer(8'h77, 1);
    check_vec("err_kept_tx", tx_count, 10);

    // Long ack hold in WAIT_LO
    push_byte(8'h5A);
    slave_xfer(8'h5A, 6);
    check_vec("hold_tx", tx_count, 11);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_vec("clr_idle_noeff", timeout_err, 0);
    check_vec("clr_idle_busy", busy, 0);

    // Reset while in REQ_HI with two bytes still queued
    ack = 1'b1;
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    ack = 1'b0;
    tick();
    check_vec("mid_req", req, 1);
    rst = 1'b0;
    #1;
    check_vec("mid_rst_req", req, 0);
    check_vec("mid_rst_busy", busy, 0);
    check_vec("mid_rst_tx", tx_count, 0);
    check_vec("mid_rst_data", data, 0);
    check_vec("mid_rst_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_vec("post_rst_req", req, 0);
    end
    check_vec("post_rst_busy", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
